// File: rtl/dti_mem_req_arbiter.sv
// Round-robin arbiter that shares one adapter memory-request port between r0 (fetch) and r1 (load/store).
// Optional abort of stalled transactions is enabled by defining DTI_ARB_TIMEOUT_EN.
module dti_mem_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_data_in,
  input  logic [1:0]        r0_data_size,
  input  logic              r0_read_req,
  input  logic              r0_write_req,
  output logic [DATA_W-1:0] r0_data_out,
  output logic              r0_read_ack,
  output logic              r0_write_ack,
  output logic              r0_err,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_data_in,
  input  logic [1:0]        r1_data_size,
  input  logic              r1_read_req,
  input  logic              r1_write_req,
  output logic [DATA_W-1:0] r1_data_out,
  output logic              r1_read_ack,
  output logic              r1_write_ack,
  output logic              r1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_data_size,
  output logic              mem_read_req,
  output logic              mem_write_req,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_read_ack,
  input  logic              mem_write_ack
);

  // state    | meaning
  // IDLE     | no transaction downstream; grant a pending slot if any
  // WAIT_ACK | one transaction issued, waiting for the adapter ack
  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state, state_next;
  logic   grant, grant_next, last_grant;
  logic   issue, complete, timeout, expired;

  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic [1:0]        req_size [2];
  logic [1:0]        req_rd, req_wr;

  logic [1:0]        pend_valid, pend_rw;
  logic [ADDR_W-1:0] pend_addr [2];
  logic [DATA_W-1:0] pend_data [2];
  logic [1:0]        pend_size [2];

  logic [DATA_W-1:0] data_out [2];
  logic [1:0]        read_ack, write_ack;

  assign req_addr[0] = r0_address;
  assign req_addr[1] = r1_address;
  assign req_data[0] = r0_data_in;
  assign req_data[1] = r1_data_in;
  assign req_size[0] = r0_data_size;
  assign req_size[1] = r1_data_size;
  assign req_rd      = {r1_read_req, r0_read_req};
  assign req_wr      = {r1_write_req, r0_write_req};

  assign r0_data_out  = data_out[0];
  assign r1_data_out  = data_out[1];
  assign r0_read_ack  = read_ack[0];
  assign r1_read_ack  = read_ack[1];
  assign r0_write_ack = write_ack[0];
  assign r1_write_ack = write_ack[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (complete) last_grant <= grant;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    issue      = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (|pend_valid) begin
          issue      = 1'b1;
          state_next = WAIT_ACK;
          // a single pending slot wins outright; a tie goes to the one not served last
          grant_next = (&pend_valid) ? ~last_grant : pend_valid[1];
        end
      end
      WAIT_ACK: begin
        if (mem_read_ack || mem_write_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (expired) begin
          complete   = 1'b1;
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid    <= '0;
      pend_rw       <= '0;
      mem_address   <= '0;
      mem_data_in   <= '0;
      mem_data_size <= '0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      read_ack      <= '0;
      write_ack     <= '0;
      for (int n = 0; n < 2; n++) begin
        pend_addr[n] <= '0;
        pend_data[n] <= '0;
        pend_size[n] <= '0;
        data_out[n]  <= '0;
      end
    end else begin
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      read_ack      <= '0;
      write_ack     <= '0;

      if (issue) begin
        mem_address   <= pend_addr[grant_next];
        mem_data_in   <= pend_data[grant_next];
        mem_data_size <= pend_size[grant_next];
        mem_write_req <= pend_rw[grant_next];
        mem_read_req  <= ~pend_rw[grant_next];
      end

      // ack type follows the captured request, not the adapter's ack type
      if (complete) begin
        if (pend_rw[grant]) begin
          write_ack[grant] <= 1'b1;
        end else begin
          read_ack[grant] <= 1'b1;
          data_out[grant] <= timeout ? '0 : mem_data_out;
        end
      end

      for (int n = 0; n < 2; n++) begin
        if (complete && (grant == n[0])) begin
          pend_valid[n] <= 1'b0;
        end else if (!pend_valid[n] && (req_rd[n] || req_wr[n])) begin
          pend_valid[n] <= 1'b1;
          pend_rw[n]    <= req_wr[n];
          pend_addr[n]  <= req_addr[n];
          pend_data[n]  <= req_data[n];
          pend_size[n]  <= req_size[n];
        end
      end
    end
  end

`ifdef DTI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       err;

  assign expired = (state == WAIT_ACK) && (tmo_cnt == '0);
  assign r0_err  = err[0];
  assign r1_err  = err[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (issue) begin
      tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if ((state == WAIT_ACK) && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= '0;
    end else begin
      err <= '0;
      if (complete) err[grant] <= timeout;
    end
  end
`else
  assign expired = 1'b0;
  assign r0_err  = 1'b0;
  assign r1_err  = 1'b0;
`endif

endmodule

// File: tb/tb_dti_mem_req_arbiter.sv
// Bench for dti_mem_req_arbiter: directed cases plus randomized rounds against a transaction-level model.
module tb_dti_mem_req_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_din  [2];
  logic [1:0]    r_size [2];
  logic          r_rd   [2];
  logic          r_wr   [2];
  logic [DW-1:0] r0_data_out, r1_data_out;
  logic          r0_read_ack, r0_write_ack, r0_err;
  logic          r1_read_ack, r1_write_ack, r1_err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic [1:0]    mem_data_size;
  logic          mem_read_req, mem_write_req, mem_read_ack, mem_write_ack;

  int checks   = 0;
  int failures = 0;

  // model state and per-requester transaction descriptors
  logic          last_grant_m;
  logic [DW-1:0] dout_m   [2];
  logic [AW-1:0] t_addr   [2];
  logic [DW-1:0] t_data   [2];
  logic [1:0]    t_size   [2];
  logic          t_wr     [2];
  logic          t_both   [2];
  logic          t_wrong  [2];
  logic          t_repulse[2];
  int            t_delay  [2];
  logic [DW-1:0] t_rdata  [2];

  always #5 clk = ~clk;

  dti_mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .r0_address(r_addr[0]), .r0_data_in(r_din[0]), .r0_data_size(r_size[0]),
    .r0_read_req(r_rd[0]), .r0_write_req(r_wr[0]), .r0_data_out(r0_data_out),
    .r0_read_ack(r0_read_ack), .r0_write_ack(r0_write_ack), .r0_err(r0_err),
    .r1_address(r_addr[1]), .r1_data_in(r_din[1]), .r1_data_size(r_size[1]),
    .r1_read_req(r_rd[1]), .r1_write_req(r_wr[1]), .r1_data_out(r1_data_out),
    .r1_read_ack(r1_read_ack), .r1_write_ack(r1_write_ack), .r1_err(r1_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_size(mem_data_size),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_data_out(mem_data_out),
    .mem_read_ack(mem_read_ack), .mem_write_ack(mem_write_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [5:0] exp_acks);
    check({tag, "_acks"}, {r1_err, r1_write_ack, r1_read_ack, r0_err, r0_write_ack, r0_read_ack}, exp_acks);
    check({tag, "_dout0"}, r0_data_out, dout_m[0]);
    check({tag, "_dout1"}, r1_data_out, dout_m[1]);
  endtask

  task automatic clear_pulses();
    r_rd[0] = 1'b0; r_rd[1] = 1'b0;
    r_wr[0] = 1'b0; r_wr[1] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dout_m[0]    = '0;
    dout_m[1]    = '0;
    last_grant_m = 1'b1;
  endtask

  task automatic set_txn(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] s,
                         input logic wr, input int dly, input logic [DW-1:0] rdat, input logic rep);
    t_addr[n] = a; t_data[n] = d; t_size[n] = s; t_wr[n] = wr; t_both[n] = 1'b0;
    t_wrong[n] = 1'b0; t_repulse[n] = rep; t_delay[n] = dly; t_rdata[n] = rdat;
  endtask

  task automatic rand_txn(input int n);
    t_addr[n]    = $urandom;
    t_data[n]    = $urandom;
    t_size[n]    = 2'($urandom_range(0, 3));
    t_wr[n]      = 1'($urandom_range(0, 1));
    t_both[n]    = t_wr[n] && ($urandom_range(0, 2) == 0);
    t_wrong[n]   = ($urandom_range(0, 3) == 0);
    t_repulse[n] = ($urandom_range(0, 3) == 0);
    t_delay[n]   = $urandom_range(0, 4);
    t_rdata[n]   = $urandom;
  endtask

  // Pulse the requesters in mask together, then serve each in round-robin order.
  task automatic run_round(input logic [1:0] mask);
    int order[$];
    int g;
    logic [5:0] e;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      if (mask[n]) begin
        r_addr[n] = t_addr[n]; r_din[n] = t_data[n]; r_size[n] = t_size[n];
        r_wr[n] = t_wr[n];
        r_rd[n] = !t_wr[n] || t_both[n];
      end
    end
    @(negedge clk);
    clear_pulses();
    if (mask == 2'b11) begin
      g = last_grant_m ? 0 : 1;
      order.push_back(g);
      order.push_back(1 - g);
    end else begin
      order.push_back(mask[1] ? 1 : 0);
    end
    foreach (order[i]) begin
      g = order[i];
      @(negedge clk);
      check("issue_req", {mem_read_req, mem_write_req}, {!t_wr[g], t_wr[g]});
      check("issue_addr", mem_address, t_addr[g]);
      check("issue_data", mem_data_in, t_data[g]);
      check("issue_size", mem_data_size, t_size[g]);
      @(negedge clk);
      check("req_pulse", {mem_read_req, mem_write_req}, 2'b00);
      check_outs("wait", 6'd0);
      if (t_repulse[g]) begin
        r_addr[g] = ~t_addr[g]; r_din[g] = ~t_data[g]; r_size[g] = ~t_size[g];
        r_rd[g] = t_wr[g]; r_wr[g] = !t_wr[g];
        @(negedge clk);
        clear_pulses();
      end
      repeat (t_delay[g]) @(negedge clk);
      check("hold_addr", mem_address, t_addr[g]);
      check("hold_data", mem_data_in, t_data[g]);
      mem_data_out = t_rdata[g];
      if (t_wr[g] ^ t_wrong[g]) mem_write_ack = 1'b1;
      else mem_read_ack = 1'b1;
      @(negedge clk);
      mem_read_ack  = 1'b0;
      mem_write_ack = 1'b0;
      if (!t_wr[g]) dout_m[g] = t_rdata[g];
      last_grant_m = g[0];
      e = (t_wr[g] ? 6'b000010 : 6'b000001) << (3 * g);
      check_outs("done", e);
    end
    @(negedge clk);
    check("idle_req", {mem_read_req, mem_write_req}, 2'b00);
    check_outs("idle", 6'd0);
  endtask

  task automatic stray_ack();
    @(negedge clk);
    mem_data_out = $urandom;
    if ($urandom_range(0, 1) == 1) mem_write_ack = 1'b1;
    else mem_read_ack = 1'b1;
    @(negedge clk);
    mem_read_ack  = 1'b0;
    mem_write_ack = 1'b0;
    check_outs("stray", 6'd0);
    check("stray_req", {mem_read_req, mem_write_req}, 2'b00);
    @(negedge clk);
    check("stray_req2", {mem_read_req, mem_write_req}, 2'b00);
  endtask

  initial begin
    int seen;
    logic seen_err;
    logic [DW-1:0] seen_dout;
    logic [1:0] mask;

    reset = 1'b1;
    clear_pulses();
    for (int n = 0; n < 2; n++) begin
      r_addr[n] = '0; r_din[n] = '0; r_size[n] = '0;
    end
    mem_data_out = '0; mem_read_ack = 1'b0; mem_write_ack = 1'b0;
    dout_m[0] = '0; dout_m[1] = '0; last_grant_m = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem", {mem_address, mem_data_size, mem_read_req, mem_write_req}, '0);
    check("rst_mem_data", mem_data_in, '0);
    check_outs("rst", 6'd0);
    reset = 1'b0;

    // tie right after reset: r0 wins, then r1
    set_txn(0, 32'h0000_0010, 32'h1111_1111, 2'b10, 1'b0, 1, 32'h0a0a_0a0a, 1'b0);
    set_txn(1, 32'h0000_0020, 32'h2222_2222, 2'b11, 1'b1, 0, 32'h0, 1'b0);
    run_round(2'b11);
    set_txn(0, 32'h0000_0030, 32'h3333_3333, 2'b00, 1'b1, 2, 32'h0, 1'b0);
    set_txn(1, 32'h0000_0040, 32'h4444_4444, 2'b01, 1'b0, 1, 32'h5555_aaaa, 1'b0);
    run_round(2'b11);

    set_txn(0, 32'h0000_0100, 32'h0000_00ab, 2'b01, 1'b1, 2, 32'h0, 1'b0);
    run_round(2'b01);
    set_txn(1, 32'h0000_0200, 32'h0, 2'b10, 1'b0, 1, 32'hdead_beef, 1'b0);
    run_round(2'b10);

    // re-pulse while pending must not create a second transaction
    set_txn(0, 32'h0000_0300, 32'h0000_0077, 2'b00, 1'b0, 2, 32'hcafe_f00d, 1'b1);
    run_round(2'b01);
    stray_ack();

    // reset while waiting for the ack; the late ack must be ignored
    @(negedge clk);
    r_addr[0] = 32'h0000_0400; r_din[0] = 32'h0; r_size[0] = 2'b10; r_rd[0] = 1'b1;
    @(negedge clk);
    clear_pulses();
    @(negedge clk);
    check("rst_mid_issue", {mem_read_req, mem_write_req}, 2'b10);
    do_reset();
    check("rst_mid_mem", {mem_address, mem_data_size, mem_read_req, mem_write_req}, '0);
    check_outs("rst_mid", 6'd0);
    mem_data_out = 32'h1234_5678;
    mem_read_ack = 1'b1;
    @(negedge clk);
    mem_read_ack = 1'b0;
    check_outs("rst_late_ack", 6'd0);
    check("rst_late_req", {mem_read_req, mem_write_req}, 2'b00);
    set_txn(0, 32'h0000_0500, 32'h0000_0099, 2'b01, 1'b0, 0, 32'h0bad_c0de, 1'b0);
    run_round(2'b01);

    // stalled transaction: aborts after TMO cycles only with the timeout build
    @(negedge clk);
    r_addr[0] = 32'h0000_0600; r_din[0] = 32'h0; r_size[0] = 2'b00; r_rd[0] = 1'b1;
    @(negedge clk);
    clear_pulses();
    @(negedge clk);
    check("tmo_issue", {mem_read_req, mem_write_req}, 2'b10);
    seen = 0; seen_err = 1'b0; seen_dout = '1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (r0_read_ack && (seen == 0)) begin
        seen = k; seen_err = r0_err; seen_dout = r0_data_out;
      end
    end
`ifdef DTI_ARB_TIMEOUT_EN
    check("tmo_cycles", seen, TMO);
    check("tmo_err", seen_err, 1'b1);
    check("tmo_dout", seen_dout, '0);
`else
    check("no_tmo_ack", seen, 0);
`endif
    do_reset();

    for (int r = 0; r < 40; r++) begin
      mask = 2'($urandom_range(1, 3));
      rand_txn(0);
      rand_txn(1);
      run_round(mask);
      if ($urandom_range(0, 4) == 0) stray_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
